// File: rtl/sqrt_unit.sv
// Bit-serial restoring integer square root: floor(sqrt(x)) and remainder,
// one root bit per cycle, with valid/ready handshakes on both sides.
module sqrt_unit #(
  parameter int  WIDTH = 16,
  localparam int RW    = WIDTH / 2,
  localparam int CW    = $clog2(WIDTH / 2 + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [WIDTH-1:0] x_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [RW-1:0]   root_o,
  output logic [RW:0]     rem_o,
  output logic            busy_o
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; valid may not drop and data may not change until then.

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("sqrt_unit: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_sr_q, x_sr_d;
  logic [RW:0]      rem_q, rem_d;
  logic [RW-1:0]    root_q, root_d;
  logic [CW-1:0]    count_q, count_d;

  logic [RW+2:0]    rem_t, trial;
  logic             take;
  logic             load;
  logic             last_iter;

  // State register and datapath flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_sr_q  <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_sr_q  <= x_sr_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      count_q <= count_d;
    end
  end

  assign load      = in_valid_i & in_ready_o;
  assign last_iter = (count_q == CW'(RW - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = CALC;
      CALC: if (last_iter) state_d = DONE;
      DONE: begin
        if (load)             state_d = CALC;
        else if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: bring down two operand bits, try subtracting 4*root+1
  always_comb begin
    rem_t = {rem_q, x_sr_q[WIDTH-1 -: 2]};
    trial = {1'b0, root_q, 2'b01};
    take  = (rem_t >= trial);

    x_sr_d  = x_sr_q;
    rem_d   = rem_q;
    root_d  = root_q;
    count_d = count_q;

    if (load) begin
      x_sr_d  = x_i;
      rem_d   = '0;
      root_d  = '0;
      count_d = '0;
    end else if (state_q == CALC) begin
      // The true remainder always fits RW+1 bits, so the low slice is exact.
      rem_d   = take ? (rem_t[RW:0] - trial[RW:0]) : rem_t[RW:0];
      root_d  = (root_q << 1) | RW'(take);
      x_sr_d  = x_sr_q << 2;
      count_d = count_q + CW'(1);
    end
  end

  // Outputs
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: in_ready_o = ~rst_i;
      CALC: busy_o = 1'b1;
      DONE: begin
        in_ready_o  = ~rst_i & out_ready_i;
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign root_o = root_q;
  assign rem_o  = rem_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// Directed bench for sqrt_unit: a WIDTH=16 instance for most scenarios and a
// WIDTH=8 instance for the narrow-width boundaries.
module tb_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] x_in;
  logic [7:0]  root;
  logic [8:0]  rem;

  logic        in8_valid, in8_ready, out8_valid, out8_ready, busy8;
  logic [7:0]  x8_in;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  int errors = 0;
  int checks = 0;

  // Clock / reset
  always #5 clk = ~clk;

  sqrt_unit #(.WIDTH(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .x_i(x_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .root_o(root), .rem_o(rem), .busy_o(busy)
  );

  sqrt_unit #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in8_valid), .in_ready_o(in8_ready), .x_i(x8_in),
    .out_valid_o(out8_valid), .out_ready_i(out8_ready),
    .root_o(root8), .rem_o(rem8), .busy_o(busy8)
  );

  // Driver: present an operand until accepted; returns one step after the accept edge.
  task automatic accept(input logic [15:0] x);
    int   n = 0;
    logic rdy = 1'b0;
    in_valid = 1'b1;
    x_in     = x;
    while (!rdy && n < 50) begin
      #1 rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL accept_timeout x=%0d: in_ready never seen within %0d cycles", x, n);
    end
  endtask

  // Driver: count rising edges until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid low after %0d cycles", n);
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; x_in = 16'd77; out_ready = 1'b1;
    in8_valid = 1'b1; x8_in = 8'd9; out8_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || in8_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b required 0/0", in_ready, in8_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || root !== 8'd0 || rem !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b root=%0d rem=%0d required 0 0 0 0",
               out_valid, busy, root, rem);
    end
    checks++;
    if (out8_valid !== 1'b0 || busy8 !== 1'b0 || root8 !== 4'd0 || rem8 !== 5'd0) begin
      errors++;
      $display("FAIL reset_state8: valid=%b busy=%b root=%0d rem=%0d required 0 0 0 0",
               out8_valid, busy8, root8, rem8);
    end
    in_valid = 1'b0; out_ready = 1'b0; in8_valid = 1'b0; out8_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] xs[2]  = '{16'd144, 16'd145};
    logic [7:0]  er[2]  = '{8'd12, 8'd12};
    logic [8:0]  em[2]  = '{9'd0, 9'd1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      accept(xs[i]);
      wait_result(lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL basic_latency x=%0d: got %0d cycles required 8", xs[i], lat);
      end
      checks++;
      if (root !== er[i] || rem !== em[i]) begin
        errors++;
        $display("FAIL basic_result x=%0d: got (%0d,%0d) required (%0d,%0d)",
                 xs[i], root, rem, er[i], em[i]);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_done_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
      end
      retire();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_single_retire: valid=%b busy=%b required 0 0", out_valid, busy);
      end
    end
  endtask

  task automatic test_bounds();
    logic [15:0] xs[2] = '{16'd0, 16'd65535};
    logic [7:0]  er[2] = '{8'd0, 8'd255};
    logic [8:0]  em[2] = '{9'd0, 9'd510};
    int lat;
    for (int i = 0; i < 2; i++) begin
      accept(xs[i]);
      wait_result(lat);
      checks++;
      if (root !== er[i] || rem !== em[i]) begin
        errors++;
        $display("FAIL bounds x=%0d: got (%0d,%0d) required (%0d,%0d)",
                 xs[i], root, rem, er[i], em[i]);
      end
      retire();
    end
  endtask

  task automatic test_width8();
    logic [7:0] xs[2] = '{8'd255, 8'd2};
    logic [3:0] er[2] = '{4'd15, 4'd1};
    logic [4:0] em[2] = '{5'd30, 5'd1};
    int n;
    for (int i = 0; i < 2; i++) begin
      in8_valid = 1'b1; x8_in = xs[i];
      #1;
      checks++;
      if (in8_ready !== 1'b1) begin
        errors++;
        $display("FAIL w8_ready: got %b required 1", in8_ready);
      end
      @(posedge clk); #1;
      in8_valid = 1'b0;
      n = 0;
      while (!out8_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL w8_latency x=%0d: got %0d cycles required 4", xs[i], n);
      end
      checks++;
      if (root8 !== er[i] || rem8 !== em[i]) begin
        errors++;
        $display("FAIL w8_result x=%0d: got (%0d,%0d) required (%0d,%0d)",
                 xs[i], root8, rem8, er[i], em[i]);
      end
      out8_ready = 1'b1;
      @(posedge clk); #1;
      out8_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept(16'd1000);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || root !== 8'd31 || rem !== 9'd39 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b root=%0d rem=%0d in_ready=%b required 1 31 39 0",
                 c, out_valid, root, rem, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_turnaround_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_retire: valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs[3] = '{16'd49, 16'd50, 16'd63};
    logic [7:0]  er[3] = '{8'd7, 8'd7, 8'd7};
    logic [8:0]  em[3] = '{9'd0, 9'd1, 9'd14};
    logic [7:0]  r[3];
    logic [8:0]  m[3];
    int   t[3];
    int   idx = 0, got = 0, cyc = 0;
    logic vld, rdy;
    x_in = xs[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      #1;
      vld = out_valid;
      rdy = in_ready;
      if (vld) begin
        r[got] = root; m[got] = rem; t[got] = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy && idx < 3) begin
        idx++;
        if (idx < 3) x_in = xs[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required 3", got);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (r[i] !== er[i] || m[i] !== em[i]) begin
          errors++;
          $display("FAIL b2b_result %0d: got (%0d,%0d) required (%0d,%0d)",
                   i, r[i], m[i], er[i], em[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t[i] - t[i-1] !== 9) begin
          errors++;
          $display("FAIL b2b_spacing %0d: got %0d cycles required 9", i, t[i] - t[i-1]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    accept(16'd900);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || root !== 8'd0 || rem !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_state: valid=%b busy=%b root=%0d rem=%0d required 0 0 0 0",
               out_valid, busy, root, rem);
    end
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_stale: got %0d valid cycles required 0", seen);
    end
    accept(16'd900);
    wait_result(lat);
    checks++;
    if (lat !== 8 || root !== 8'd30 || rem !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_fresh: lat=%0d root=%0d rem=%0d required 8 30 0", lat, root, rem);
    end
    retire();
  endtask

  task automatic test_sweep();
    logic [15:0] xs[12] = '{16'd1, 16'd3, 16'd4, 16'd15, 16'd16, 16'd255,
                            16'd256, 16'd1023, 16'd4095, 16'd32767, 16'd32768, 16'd65534};
    int lat, r, x;
    for (int i = 0; i < 12; i++) begin
      x = int'(xs[i]);
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      accept(xs[i]);
      wait_result(lat);
      checks++;
      if (int'(root) !== r || int'(rem) !== x - r * r) begin
        errors++;
        $display("FAIL sweep x=%0d: got (%0d,%0d) required (%0d,%0d)",
                 x, root, rem, r, x - r * r);
      end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_width8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_unit.md
Name: sqrt_unit

Overview:
Parametrised, self-contained integer square-root engine. It returns floor(sqrt(x)) and the remainder x - root^2 for an unsigned WIDTH-bit operand. The datapath is a bit-serial restoring digit-by-digit datapath that resolves one root bit per cycle, giving fixed latency WIDTH/2. It sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides, and supersedes the fixed 8-bit odd-summation controller/datapath pair.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 2 (elaboration error otherwise)
RW, WIDTH/2, root width (derived, not overridable)
CW, $clog2(WIDTH/2+1), iteration counter width (derived)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  operand valid
in_ready_o  out  1  unit can accept operand this cycle
x_i  in  WIDTH  unsigned operand
out_valid_o  out  1  result valid, held until accepted
out_ready_i  in  1  consumer accepts result
root_o  out  RW  floor(sqrt(x))
rem_o  out  RW+1  x - root^2 (max 2*root)
busy_o  out  1  state != IDLE

Behaviour:
- Reset: rst_i high at a rising edge forces state=IDLE, counter=0, x_sr=0, rem=0, root=0. After that edge, out_valid_o=0, root_o=0, rem_o=0, busy_o=0. in_ready_o=0 whenever rst_i=1.
- Reset mid-operation (CALC or DONE) aborts immediately; the in-flight result is discarded and never presented.
- States: IDLE, CALC, DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o: x_sr<=x_i, rem<=0, root<=0, count<=0, go to CALC.
- CALC: in_ready_o=0. Each cycle:
  - rem_t = {rem, x_sr[WIDTH-1:WIDTH-2]}
  - trial = {root, 2'b01}
  - if rem_t >= trial: rem <= rem_t - trial, root <= {root, 1}; else rem <= rem_t, root <= {root, 0}
  - x_sr <= x_sr << 2; count++
  - After the iteration where count reaches RW-1, go to DONE.
  - Internal rem_t/trial are RW+3 bits wide; stored rem never exceeds RW+1 bits.
- DONE: out_valid_o=1; root_o/rem_o stable until handshake. On out_ready_i: go to IDLE, unless the same-cycle accept below applies.
- Same-cycle turnaround: in DONE, in_ready_o = out_ready_i. If out_ready_i & in_valid_i in the same cycle, the result is retired and the new operand captured, going directly to CALC.
- Latency: operand accepted at edge E -> out_valid_o high in the cycle after edge E+RW. Sustained throughput is one result per RW+1 cycles.
- root_o/rem_o keep their last value outside DONE. They are meaningful only while out_valid_o=1.
- in_valid_i outside IDLE/DONE is ignored; the producer must hold x_i until accepted.
- busy_o=1 in CALC and DONE.
- Boundaries:
  - x=0 -> root 0, rem 0
  - x=2^WIDTH-1 -> root 2^RW-1, rem 2^(RW+1)-2; no overflow at any width
  - out_ready_i held high in DONE for one cycle without in_valid_i -> exactly one result retired

Test Plan:
- WIDTH=16, x=144 then x=145 -> root 12/rem 0, then root 12/rem 1; out_valid_o first rises 8 cycles after each accept edge.
- WIDTH=16, x=0 and x=65535 -> (0,0) and (255,510). WIDTH=8 (rebuild), x=255 -> (15,30); x=2 -> (1,1).
- Backpressure: x=1000, out_ready_i low 5 cycles after out_valid_o -> root 31/rem 39 held stable, in_ready_o=0 throughout; single retire when out_ready_i rises.
- Back-to-back: in_valid_i always high with x=49,50,63 and out_ready_i=1 -> results (7,0),(7,1),(7,14) spaced exactly 9 cycles apart, with no bubble beyond the turnaround cycle.
- Reset mid-CALC (4 cycles after accepting x=900) -> next cycle out_valid_o=0, busy_o=0, root_o=0. A fresh x=900 afterwards yields (30,0) with no stale result emitted.
- Random 10k operands at WIDTH=16 and WIDTH=32 against a reference model: root^2 + rem == x and rem <= 2*root for every result.
